// File: rtl/blackjack_buttons_pkg.sv
// Shared constants and helpers for the blackjack button front end.
// Contents:
//   - button index constants into btn_raw / btn_level
//   - event codes presented to the game core
//   - pick_event: priority selection among pending buttons
//   - event_mask: one-hot pending bit belonging to an event code
package blackjack_pkg;

  localparam int NUM_BTN = 4;

  localparam int BTN_HIT    = 0;
  localparam int BTN_STAND  = 1;
  localparam int BTN_DOUBLE = 2;
  localparam int BTN_FINISH = 3;

  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_HIT    = 2'd0;
  localparam evt_code_t EVT_STAND  = 2'd1;
  localparam evt_code_t EVT_DOUBLE = 2'd2;
  localparam evt_code_t EVT_FINISH = 2'd3;

  // Priority: finish > stand > double > hit. Returns EVT_HIT when nothing
  // is pending, so callers must qualify the result with |pend.
  function automatic evt_code_t pick_event(input logic [NUM_BTN-1:0] pend);
    if (pend[BTN_FINISH])      return EVT_FINISH;
    else if (pend[BTN_STAND])  return EVT_STAND;
    else if (pend[BTN_DOUBLE]) return EVT_DOUBLE;
    else                       return EVT_HIT;
  endfunction

  function automatic logic [NUM_BTN-1:0] event_mask(input evt_code_t code);
    logic [NUM_BTN-1:0] mask;
    mask = '0;
    case (code)
      EVT_FINISH: mask[BTN_FINISH] = 1'b1;
      EVT_STAND:  mask[BTN_STAND]  = 1'b1;
      EVT_DOUBLE: mask[BTN_DOUBLE] = 1'b1;
      default:    mask[BTN_HIT]    = 1'b1;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/blackjack_buttons_if.sv
// Event handshake between the button front end and the game core.
// Signals:
//   evt_valid - an event is presented (front end -> core)
//   evt_code  - event code, one of the EVT_* constants (front end -> core)
//   evt_ready - core accepts the presented event (core -> front end)
// Modports: master = front end, slave = game core.
interface blackjack_buttons_if;
  import blackjack_pkg::*;

  logic      evt_valid;
  logic      evt_ready;
  evt_code_t evt_code;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/blackjack_buttons_btn_debounce.sv
// Single-button conditioner: two-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on the level's rising edge.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   raw      - asynchronous button input
//   level    - debounced level
//   press    - high for one cycle after level rises
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             level_next;
  logic             level_d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Counter only runs while the synced input disagrees with the level; any
  // agreeing cycle restarts the window, so bounces never accumulate. The
  // counter clears at CNT_LAST and therefore never wraps.
  always_comb begin
    cnt_next   = '0;
    level_next = level_reg;
    if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
    end else begin
      sync1_reg   <= raw;
      sync2_reg   <= sync1_reg;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      level_d_reg <= level_reg;
    end
  end

  assign level = level_reg;
  assign press = level_reg & ~level_d_reg;

endmodule

// File: rtl/blackjack_buttons.sv
// Blackjack button front end: debounces four buttons, records presses as
// pending bits and presents them one at a time to the game core over a
// valid/ready handshake, highest priority first.
// Ports:
//   clk_25MHz - system clock
//   rst       - asynchronous active-high reset
//   btn_raw   - raw buttons [0] hit, [1] stand, [2] double, [3] finish
//   evt_bus   - event handshake (master side)
//   btn_level - debounced button levels
module blackjack_buttons
  import blackjack_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic                 clk_25MHz,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_raw,
  blackjack_buttons_if.master  evt_bus,
  output logic [NUM_BTN-1:0]   btn_level
);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending_reg;
  logic [NUM_BTN-1:0] pending_next;
  logic [NUM_BTN-1:0] grant_mask;
  evt_code_t          grant_code;
  evt_code_t          code_reg;
  evt_code_t          code_next;
  logic               valid_reg;
  logic               valid_next;
  logic               load;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_debounce (
        .clk   (clk_25MHz),
        .rst   (rst),
        .raw   (btn_raw[gi]),
        .level (btn_level[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  // The output register refills whenever it is empty or being drained, so
  // ready is irrelevant while nothing is presented.
  assign load = ~valid_reg | evt_bus.evt_ready;

  always_comb begin
    grant_code   = pick_event(pending_reg);
    grant_mask   = event_mask(grant_code) & pending_reg;
    valid_next   = valid_reg;
    code_next    = code_reg;
    // A press ORs in after the grant clears its bit, so re-pressing the
    // button being handed over queues a fresh event instead of being lost.
    pending_next = pending_reg | press;
    if (load) begin
      valid_next = |pending_reg;
      if (|pending_reg) begin
        code_next    = grant_code;
        pending_next = (pending_reg & ~grant_mask) | press;
      end
    end
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      code_reg    <= EVT_HIT;
    end else begin
      pending_reg <= pending_next;
      valid_reg   <= valid_next;
      code_reg    <= code_next;
    end
  end

  assign evt_bus.evt_valid = valid_reg;
  assign evt_bus.evt_code  = code_reg;

endmodule

// File: tb/tb_blackjack_buttons.sv
// Directed bench for blackjack_buttons with a 4-cycle debounce window.
module tb_blackjack_buttons;
  import blackjack_pkg::*;

  localparam int DEB = 4;

  logic       clk_25MHz = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;

  int n_checks = 0;
  int n_fail   = 0;

  blackjack_buttons_if bus ();

  blackjack_buttons #(
    .DEB_CYCLES (DEB)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .evt_bus   (bus.master),
    .btn_level (btn_level)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_25MHz);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    btn_raw       = 4'b0000;
    bus.evt_ready = 1'b0;
    #5;
    check("rst_valid", bus.evt_valid, 0);
    check("rst_code", bus.evt_code, 0);
    check("rst_level", btn_level, 0);
    step(2);
    rst = 1'b0;
    step(3);
    check("idle_valid", bus.evt_valid, 0);

    // Hit press with ready high: level after edge 6, event after edge 8 only.
    bus.evt_ready = 1'b1;
    btn_raw       = 4'b0001;
    for (int e = 1; e <= 9; e++) begin
      step(1);
      check($sformatf("hit_level_e%0d", e), btn_level, (e >= 6) ? 4'b0001 : 4'b0000);
      check($sformatf("hit_valid_e%0d", e), bus.evt_valid, (e == 8) ? 1 : 0);
      if (e == 8) check("hit_code_e8", bus.evt_code, EVT_HIT);
      $display("hit edge %0d: valid=%0b code=%0d level=%b", e, bus.evt_valid, bus.evt_code, btn_level);
    end
    btn_raw = 4'b0000;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      check($sformatf("hit_release_valid_e%0d", e), bus.evt_valid, 0);
    end
    check("hit_release_level", btn_level, 0);

    // Stand bouncing every 2 cycles never settles.
    for (int c = 0; c < 40; c++) begin
      btn_raw[BTN_STAND] = ((c / 2) % 2) == 0;
      step(1);
      check($sformatf("bounce_level_c%0d", c), btn_level[BTN_STAND], 0);
      check($sformatf("bounce_valid_c%0d", c), bus.evt_valid, 0);
    end
    btn_raw = 4'b0000;
    step(6);
    check("bounce_after_valid", bus.evt_valid, 0);
    $display("bounce: level=%b valid=%0b", btn_level, bus.evt_valid);

    // Hit, double and finish together: codes 3, 2, 0 back to back.
    btn_raw = 4'b1101;
    for (int e = 1; e <= 11; e++) begin
      step(1);
      if (e == 6) check("multi_level_e6", btn_level, 4'b1101);
      check($sformatf("multi_valid_e%0d", e), bus.evt_valid, (e >= 8 && e <= 10) ? 1 : 0);
      if (e == 8)  check("multi_code_e8", bus.evt_code, EVT_FINISH);
      if (e == 9)  check("multi_code_e9", bus.evt_code, EVT_DOUBLE);
      if (e == 10) check("multi_code_e10", bus.evt_code, EVT_HIT);
      $display("multi edge %0d: valid=%0b code=%0d", e, bus.evt_valid, bus.evt_code);
    end
    btn_raw = 4'b0000;
    step(10);
    check("multi_drain_valid", bus.evt_valid, 0);

    // Stand press held off by ready=0 for 20 cycles, then one transfer.
    bus.evt_ready = 1'b0;
    btn_raw       = 4'b0010;
    step(8);
    check("stall_valid_e8", bus.evt_valid, 1);
    check("stall_code_e8", bus.evt_code, EVT_STAND);
    for (int c = 0; c < 20; c++) begin
      step(1);
      check($sformatf("stall_valid_c%0d", c), bus.evt_valid, 1);
      check($sformatf("stall_code_c%0d", c), bus.evt_code, EVT_STAND);
    end
    bus.evt_ready = 1'b1;
    step(1);
    check("stall_xfer_valid", bus.evt_valid, 0);
    $display("stall: transferred, valid=%0b", bus.evt_valid);
    step(1);
    check("stall_after_valid", bus.evt_valid, 0);
    bus.evt_ready = 1'b0;
    btn_raw       = 4'b0000;
    step(10);

    // Re-pressing hit while hit is presented queues a second hit event.
    btn_raw = 4'b0001;
    step(8);
    check("repress_first_valid", bus.evt_valid, 1);
    check("repress_first_code", bus.evt_code, EVT_HIT);
    btn_raw = 4'b0000;
    step(10);
    check("repress_released_level", btn_level, 0);
    btn_raw = 4'b0001;
    step(10);
    check("repress_hold_valid", bus.evt_valid, 1);
    check("repress_hold_code", bus.evt_code, EVT_HIT);
    bus.evt_ready = 1'b1;
    step(1);
    check("repress_second_valid", bus.evt_valid, 1);
    check("repress_second_code", bus.evt_code, EVT_HIT);
    step(1);
    check("repress_empty_valid", bus.evt_valid, 0);
    $display("repress: second hit delivered");
    bus.evt_ready = 1'b0;
    btn_raw       = 4'b0000;
    step(10);

    // Stand presented, finish pending, then a one-cycle reset.
    btn_raw = 4'b0010;
    step(10);
    check("rstmid_stand_valid", bus.evt_valid, 1);
    check("rstmid_stand_code", bus.evt_code, EVT_STAND);
    btn_raw = 4'b1000;
    step(10);
    check("rstmid_pending_code", bus.evt_code, EVT_STAND);
    rst = 1'b1;
    #1;
    check("rstmid_async_valid", bus.evt_valid, 0);
    check("rstmid_async_code", bus.evt_code, 0);
    check("rstmid_async_level", btn_level, 0);
    @(posedge clk_25MHz);
    #1;
    rst           = 1'b0;
    bus.evt_ready = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      step(1);
      check($sformatf("rstmid_valid_e%0d", e), bus.evt_valid, (e == 8) ? 1 : 0);
      if (e == 8) check("rstmid_code_e8", bus.evt_code, EVT_FINISH);
      $display("post-reset edge %0d: valid=%0b code=%0d", e, bus.evt_valid, bus.evt_code);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
